// File: rtl/gcd_engine.sv
// gcd_engine: valid/ready GCD unit with subtractive (MODE 0) or binary Stein (MODE 1) iteration,
// zero-operand flagging and a saturating count of RUN cycles.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int MODE  = 0,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [CNT_W-1:0] cycles,
   output logic             zero_err
);
   localparam int KW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] x, y, x_nx, y_nx, result_nx;
   logic [KW-1:0] k, k_nx;
   logic [CNT_W-1:0] cycles_nx;
   logic zero_err_nx, take, a_zero, b_zero;
   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign out_valid = (state == DONE);
   assign take = in_valid && in_ready;
   assign a_zero = (a == '0);
   assign b_zero = (b == '0);
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         x <= '0;
         y <= '0;
         k <= '0;
         result <= '0;
         cycles <= '0;
         zero_err <= 1'b0;
      end else begin
         state <= state_nx;
         x <= x_nx;
         y <= y_nx;
         k <= k_nx;
         result <= result_nx;
         cycles <= cycles_nx;
         zero_err <= zero_err_nx;
      end
   end
   // A new capture wins over everything; in DONE it also completes the pending output.
   always_comb begin
      state_nx = state;
      x_nx = x;
      y_nx = y;
      k_nx = k;
      result_nx = result;
      cycles_nx = cycles;
      zero_err_nx = zero_err;
      if (take) begin
         x_nx = a;
         y_nx = b;
         k_nx = '0;
         cycles_nx = '0;
         if (a_zero || b_zero) begin
            state_nx = DONE;
            result_nx = a | b;
            zero_err_nx = a_zero && b_zero;
         end else begin
            state_nx = RUN;
            zero_err_nx = 1'b0;
         end
      end else if (state == RUN) begin
         cycles_nx = (&cycles) ? cycles : cycles + 1'b1;
         if (x == y) begin
            state_nx = DONE;
            result_nx = (MODE != 0) ? (x << k) : x;
         end else if (MODE == 0) begin
            x_nx = (x > y) ? x - y : x;
            y_nx = (x > y) ? y : y - x;
         end else if (!x[0] && !y[0]) begin
            x_nx = x >> 1;
            y_nx = y >> 1;
            k_nx = k + 1'b1;
         end else if (!x[0]) begin
            x_nx = x >> 1;
         end else if (!y[0]) begin
            y_nx = y >> 1;
         end else begin
            x_nx = (x > y) ? x - y : x;
            y_nx = (x > y) ? y : y - x;
         end
      end else if (state == DONE && out_ready) begin
         state_nx = IDLE;
      end
   end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed vectors against both algorithm modes, with hand-computed results.
module tb_gcd_engine;
   logic clock = 0, reset = 1, sel = 0;
   logic iv0 = 0, iv1 = 0, out_ready = 0;
   logic [15:0] a = 0, b = 0;
   logic ir0, ir1, ov0, ov1, ze0, ze1;
   logic [15:0] res0, res1;
   logic [7:0] cyc0, cyc1;
   logic ir, ov, ze;
   logic [15:0] res;
   logic [7:0] cyc;
   int checks = 0, failures = 0;
   always #5 clock = ~clock;
   gcd_engine #(.WIDTH(16), .MODE(0), .CNT_W(8)) u0 (
      .clock(clock), .reset(reset), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
      .out_valid(ov0), .out_ready(out_ready), .result(res0), .cycles(cyc0), .zero_err(ze0));
   gcd_engine #(.WIDTH(16), .MODE(1), .CNT_W(8)) u1 (
      .clock(clock), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
      .out_valid(ov1), .out_ready(out_ready), .result(res1), .cycles(cyc1), .zero_err(ze1));
   assign ir = sel ? ir1 : ir0;
   assign ov = sel ? ov1 : ov0;
   assign ze = sel ? ze1 : ze0;
   assign res = sel ? res1 : res0;
   assign cyc = sel ? cyc1 : cyc0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Operands are scrambled right after the handshake; the engine must ignore them.
   task automatic start(input logic m, input logic [15:0] aa, input logic [15:0] bb);
      sel = m;
      a = aa;
      b = bb;
      iv0 = !m;
      iv1 = m;
      @(posedge clock);
      #1 iv0 = 0;
      iv1 = 0;
      a = '1;
      b = '1;
   endtask

   task automatic wait_done(input string tag, input int er, input int ec, input int ez, input int el);
      int n;
      logic bad = 0;
      for (n = 0; n < 2000; n++) begin
         @(negedge clock);
         if (ov) break;
         if (ir) bad = 1;
      end
      check({tag, "_lat"}, n, el);
      check({tag, "_busy_rdy"}, {31'd0, bad}, 0);
      check({tag, "_res"}, {16'd0, res}, er);
      check({tag, "_cyc"}, {24'd0, cyc}, ec);
      check({tag, "_zerr"}, {31'd0, ze}, ez);
   endtask

   task automatic release_out;
      out_ready = 1;
      @(posedge clock);
      #1 out_ready = 0;
      @(negedge clock);
      check("rel_idle", {31'd0, ir}, 1);
   endtask

   initial begin
      logic [15:0] r;
      logic [7:0] c;
      logic bad;
      repeat (2) @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      check("rst_ov0", {31'd0, ov0}, 0);
      check("rst_ir0", {31'd0, ir0}, 1);
      check("rst_res0", {16'd0, res0}, 0);
      check("rst_cyc0", {24'd0, cyc0}, 0);
      check("rst_ze1", {31'd0, ze1}, 0);
      start(0, 12, 8);   wait_done("m0_12_8", 4, 3, 0, 3);   release_out;
      start(1, 12, 8);   wait_done("m1_12_8", 4, 6, 0, 6);   release_out;
      start(0, 48, 18);  wait_done("m0_48_18", 6, 5, 0, 5);  release_out;
      start(1, 48, 18);  wait_done("m1_48_18", 6, 7, 0, 7);  release_out;
      start(0, 0, 9);    wait_done("m0_0_9", 9, 0, 0, 0);    release_out;
      start(0, 0, 0);    wait_done("m0_0_0", 0, 0, 1, 0);    release_out;
      start(1, 9, 0);    wait_done("m1_9_0", 9, 0, 0, 0);    release_out;
      start(1, 0, 0);    wait_done("m1_0_0", 0, 0, 1, 0);    release_out;
      start(0, 1000, 1); wait_done("m0_sat", 1, 255, 0, 1000); release_out;
      start(0, 12, 8);   wait_done("hold", 4, 3, 0, 3);
      r = res;
      c = cyc;
      bad = 0;
      repeat (5) begin
         @(negedge clock);
         if (ov !== 1 || res !== r || cyc !== c || ze !== 0) bad = 1;
      end
      check("hold_stable", {31'd0, bad}, 0);
      check("hold_rdy_low", {31'd0, ir}, 0);
      out_ready = 1;
      iv0 = 1;
      a = 7;
      b = 21;
      @(posedge clock);
      #1 out_ready = 0;
      iv0 = 0;
      a = 0;
      b = 0;
      @(negedge clock);
      check("b2b_drop", {31'd0, ov}, 0);
      wait_done("b2b", 7, 3, 0, 2);
      release_out;
      start(0, 1000, 1);
      repeat (5) @(negedge clock);
      reset = 1;
      @(posedge clock);
      #1 reset = 0;
      @(negedge clock);
      check("mid_rst_ov", {31'd0, ov}, 0);
      check("mid_rst_ir", {31'd0, ir}, 1);
      check("mid_rst_cyc", {24'd0, cyc}, 0);
      start(0, 48, 18); wait_done("after_rst", 6, 5, 0, 5); release_out;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
